display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_pkg.sv | 18 +
 rtl/display_arbiter_if.sv | 28 ++
 rtl/display_arbiter_rr_pick.sv | 33 +++
 rtl/display_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multi-requester 4-digit display arbiter.
package display_pkg;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 16;
  localparam int DOTS_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Request/grant bundle between the display requesters and the arbiter.
interface display_arbiter_if
  import display_pkg::*;
#(
  parameter int NREQ = 4
);
  // Handshake: req[i] is a level request held by requester i for as long as it
  // wants the display; grant[i] (one-hot or zero) is the acknowledgement, and
  // value/dots/blank are the registered display outputs for the current owner.
  logic [NREQ-1:0]         req;
  logic [VALUE_W*NREQ-1:0] req_value;
  logic [DOTS_W*NREQ-1:0]  req_dots;
  logic [NREQ-1:0]         grant;
  logic [VALUE_W-1:0]      value;
  logic [DOTS_W-1:0]       dots;
  logic                    blank;

  modport master (
    output req, req_value, req_dots,
    input  grant, value, dots, blank
  );

  modport slave (
    input  req, req_value, req_dots,
    output grant, value, dots, blank
  );

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    winner  = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    cidx    = '0;
    // Offsets 1..NREQ visit every index once, the previous owner last.
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last) + off) % NREQ;
      cidx = IDX_W'(cand);
      if (!valid && req[cidx]) begin
        valid        = 1'b1;
        winner[cidx] = 1'b1;
        win_idx      = cidx;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Time-sliced owner arbitration for a shared 4-digit display: IDLE -> OWN -> GAP.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 50_000_000,
  parameter int GAP   = 5_000_000
) (
  input  logic              clock,
  input  logic              reset,
  display_arbiter_if.slave  bus,
  output state_e            state_dbg
);

  localparam int CNT_W = $clog2(max_int(DWELL, GAP) + 1);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [DOTS_W-1:0]  dots_q, dots_d;
  logic               blank_q, blank_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [VALUE_W-1:0] owner_value;
  logic [DOTS_W-1:0]  owner_dots;
  logic               owner_req;
  logic               others_req;
  logic               dwell_done;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .last    (last_q),
    .winner  (pick_onehot),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    owner_value = '0;
    owner_dots  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_value = bus.req_value[i*VALUE_W +: VALUE_W];
        owner_dots  = bus.req_dots[i*DOTS_W +: DOTS_W];
      end
    end
  end

  assign owner_req  = bus.req[owner_q];
  assign others_req = |(bus.req & ~grant_q);
  assign dwell_done = (cnt_q >= DWELL_C);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    value_d = '0;
    dots_d  = '0;
    blank_d = 1'b1;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick_onehot;
          blank_d = 1'b0;
          cnt_d   = '0;
          owner_d = pick_idx;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // Past the dwell the owner yields to anyone else, or when it lets go.
        if (dwell_done && (!owner_req || others_req)) begin
          last_d  = owner_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          blank_d = 1'b0;
          value_d = owner_value;
          dots_d  = owner_dots;
          if (!dwell_done) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        grant_d = '0;
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      value_q <= '0;
      dots_q  <= '0;
      blank_q <= 1'b1;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      value_q <= value_d;
      dots_q  <= dots_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.value = value_q;
  assign bus.dots  = dots_q;
  assign bus.blank = blank_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: GAP=2 instance plus a GAP=0 instance.
module tb_display_arbiter;
  import display_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 2 + NREQ + VALUE_W + DOTS_W + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst0;

  state_e st, st0;
  display_arbiter_if #(.NREQ(NREQ)) bus  ();
  display_arbiter_if #(.NREQ(NREQ)) bus0 ();

  display_arbiter #(.NREQ(NREQ), .DWELL(4), .GAP(2)) u_dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus.slave),
    .state_dbg (st)
  );

  display_arbiter #(.NREQ(NREQ), .DWELL(4), .GAP(0)) u_dut0 (
    .clock     (clk),
    .reset     (rst0),
    .bus       (bus0.slave),
    .state_dbg (st0)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    sel = 0;
  int    cyc = 0;
  string phase = "reset";

  function automatic logic [W-1:0] pk(logic [1:0] s, logic [3:0] g, logic [15:0] v,
                                      logic [3:0] d, logic b);
    return {s, g, v, d, b};
  endfunction

  function automatic logic [W-1:0] obs_now();
    if (sel == 0) return pk(st, bus.grant, bus.value, bus.dots, bus.blank);
    return pk(st0, bus0.grant, bus0.value, bus0.dots, bus0.blank);
  endfunction

  // driver / expectation tasks
  task automatic exp_own(logic [3:0] g, logic [15:0] v, logic [3:0] d);
    exp_q.push_back(pk(ST_OWN, g, v, d, 1'b0));
  endtask

  task automatic exp_pick(logic [3:0] g);
    exp_q.push_back(pk(ST_OWN, g, 16'h0000, 4'h0, 1'b0));
  endtask

  task automatic exp_blank(state_e s);
    exp_q.push_back(pk(s, 4'h0, 16'h0000, 4'h0, 1'b1));
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, o;
      logic [3:0]   g;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      o = obs_now();
      g = o[W-3 -: 4];
      n_cmp++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cyc%0d {state,grant,value,dots,blank} observed=%h expected=%h",
               phase, cyc, o, e);
      end
      n_cmp++;
      assert (($onehot0(g) && (g != 4'h0 || o[0])) === 1'b1) else begin
        n_fail++;
        $error("FAIL %s_invariant cyc%0d grant=%b blank=%b expected one-hot0 and blank when idle",
               phase, cyc, g, o[0]);
      end
    end
  endtask

  task automatic set_slice(int i, logic [15:0] v, logic [3:0] d);
    bus.req_value[i*16 +: 16] = v;
    bus.req_dots[i*4 +: 4]    = d;
  endtask

  initial begin
    logic [3:0] g;
    rst  = 1'b1;
    rst0 = 1'b1;
    bus.req = '0;  bus.req_value = '0;  bus.req_dots = '0;
    bus0.req = '0; bus0.req_value = '0; bus0.req_dots = '0;
    @(negedge clk);

    phase = "reset";
    exp_blank(ST_IDLE); exp_blank(ST_IDLE);
    drain();

    // first grant and 1-cycle value latency
    phase = "first_grant";
    rst = 1'b0;
    set_slice(0, 16'h1234, 4'h5);
    set_slice(1, 16'hABCD, 4'hA);
    bus.req = 4'b0001;
    exp_pick(4'b0001); exp_own(4'b0001, 16'h1234, 4'h5);
    drain();

    // owner 0 holds to dwell despite a competing request, then gap, then 1
    phase = "hold_then_yield";
    bus.req = 4'b0011;
    repeat (3) exp_own(4'b0001, 16'h1234, 4'h5);
    exp_blank(ST_GAP); exp_blank(ST_GAP); exp_blank(ST_IDLE);
    exp_pick(4'b0010); exp_own(4'b0010, 16'hABCD, 4'hA);
    drain();

    // live value tracking; owner releases before dwell and is still held
    phase = "live_track";
    set_slice(1, 16'h5678, 4'h3);
    bus.req = 4'b0000;
    repeat (3) exp_own(4'b0010, 16'h5678, 4'h3);
    exp_blank(ST_GAP); exp_blank(ST_GAP); exp_blank(ST_IDLE); exp_blank(ST_IDLE);
    drain();

    // owner 2 drops at count 1 with no competition
    phase = "drop_early";
    set_slice(2, 16'hC0DE, 4'h4);
    bus.req = 4'b0100;
    exp_pick(4'b0100); exp_own(4'b0100, 16'hC0DE, 4'h4);
    drain();
    bus.req = 4'b0000;
    repeat (3) exp_own(4'b0100, 16'hC0DE, 4'h4);
    exp_blank(ST_GAP); exp_blank(ST_GAP); exp_blank(ST_IDLE); exp_blank(ST_IDLE);
    drain();

    // sole requester keeps the display past the dwell
    phase = "sole_owner";
    bus.req = 4'b0100;
    exp_pick(4'b0100);
    repeat (7) exp_own(4'b0100, 16'hC0DE, 4'h4);
    drain();

    // reset mid-OWN discards ownership; requester 0 priority restored
    phase = "reset_mid_own";
    rst = 1'b1;
    bus.req = 4'b0110;
    exp_blank(ST_IDLE);
    drain();
    rst = 1'b0;
    exp_pick(4'b0010); exp_own(4'b0010, 16'h5678, 4'h3);
    drain();

    // full rotation with GAP=2
    phase = "rotate_gap2";
    rst = 1'b1;
    exp_blank(ST_IDLE);
    drain();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_slice(i, {4{4'(i + 1)}}, 4'(1 << i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      exp_pick(g);
      repeat (4) exp_own(g, {4{4'((k % 4) + 1)}}, g);
      if (k < 4) begin
        exp_blank(ST_GAP); exp_blank(ST_GAP); exp_blank(ST_IDLE);
      end
    end
    drain();

    // full rotation with GAP=0 on the second instance
    phase = "rotate_gap0";
    sel = 1;
    for (int i = 0; i < NREQ; i++) begin
      bus0.req_value[i*16 +: 16] = {4{4'(i + 5)}};
      bus0.req_dots[i*4 +: 4]    = 4'(1 << i);
    end
    bus0.req = 4'b1111;
    exp_blank(ST_IDLE);
    drain();
    rst0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      exp_pick(g);
      repeat (4) exp_own(g, {4{4'((k % 4) + 5)}}, g);
      if (k < 4) exp_blank(ST_IDLE);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
